// File: rtl/dragon_cache_ctrl.sv
// rtl/dragon_cache_ctrl.sv - set-associative write-back cache controller, Dragon update protocol
module dragon_cache_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int SETS       = 256,
    parameter int WAYS       = 4,
    parameter int LINE_BYTES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [7:0]              req_wdata,
    output logic                    resp_valid,
    output logic [7:0]              resp_rdata,
    output logic                    resp_hit,
    output logic                    bus_req,
    input  logic                    bus_gnt,
    output logic [1:0]              bus_cmd,
    output logic [ADDR_W-1:0]       bus_addr,
    output logic [8*LINE_BYTES-1:0] bus_wdata,
    input  logic                    bus_shared,
    input  logic                    bus_rvalid,
    input  logic [8*LINE_BYTES-1:0] bus_rdata,
    input  logic                    snp_valid,
    input  logic [1:0]              snp_cmd,
    input  logic [ADDR_W-1:0]       snp_addr,
    input  logic [7:0]              snp_data,
    output logic                    snp_shared
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int LINE_W = 8 * LINE_BYTES;

    localparam logic [1:0] CMD_NONE   = 2'd0;
    localparam logic [1:0] CMD_BUSRD  = 2'd1;
    localparam logic [1:0] CMD_BUSUPD = 2'd2;
    localparam logic [1:0] CMD_FLUSH  = 2'd3;

    typedef enum logic [1:0] {CS_E, CS_SC, CS_SM, CS_M} cstate_t;
    typedef enum logic [2:0] {IDLE, LOOKUP, VICTIM, FLUSH, FILL_REQ, FILL_WAIT, UPDATE, RESPOND} state_t;

    logic [LINE_W-1:0] data_mem  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
    logic              valid_mem [SETS][WAYS];
    cstate_t           cst_mem   [SETS][WAYS];
    logic [WAY_W-1:0]  age_mem   [SETS][WAYS];

    state_t             state, state_n;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_write, r_hit;
    logic [7:0]         r_wdata;
    logic [WAY_W-1:0]   r_way;

    logic [TAG_W-1:0] r_tag, s_tag;
    logic [IDX_W-1:0] r_idx, s_idx;
    logic [OFF_W-1:0] r_off, s_off;

    assign r_tag = r_addr[ADDR_W-1 -: TAG_W];
    assign r_idx = r_addr[OFF_W +: IDX_W];
    assign r_off = r_addr[OFF_W-1:0];
    assign s_tag = snp_addr[ADDR_W-1 -: TAG_W];
    assign s_idx = snp_addr[OFF_W +: IDX_W];
    assign s_off = snp_addr[OFF_W-1:0];

    function automatic logic [LINE_W-1:0] put_byte(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0] off,
                                                   input logic [7:0] b);
        logic [LINE_W-1:0] res;
        res = line;
        res[{off, 3'b000} +: 8] = b;
        return res;
    endfunction

    logic             hit, s_hit, vic_found;
    logic [WAY_W-1:0] hit_way, s_way, vic_way;

    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        s_hit = 1'b0;
        s_way = '0;
        vic_found = 1'b0;
        vic_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_mem[r_idx][w] && tag_mem[r_idx][w] == r_tag) begin
                hit = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (valid_mem[s_idx][w] && tag_mem[s_idx][w] == s_tag) begin
                s_hit = 1'b1;
                s_way = WAY_W'(w);
            end
            if (!vic_found && !valid_mem[r_idx][w]) begin
                vic_found = 1'b1;
                vic_way = WAY_W'(w);
            end
        end
        if (!vic_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_mem[r_idx][w] == WAY_W'(WAYS-1)) vic_way = WAY_W'(w);
            end
        end
    end

    assign snp_shared = s_hit;

    logic [LINE_W-1:0] cur_line;
    cstate_t           hit_cst, cur_cst, vic_cst;
    logic [WAY_W-1:0]  fsm_way;
    logic              snp_act, collide, snp_do;
    logic              wr_byte, inv_vic, install, upd_cst, lru_touch;

    assign cur_line = data_mem[r_idx][r_way];
    assign cur_cst  = cst_mem[r_idx][r_way];
    assign hit_cst  = cst_mem[r_idx][hit_way];
    assign vic_cst  = cst_mem[r_idx][vic_way];
    assign fsm_way  = (state == LOOKUP) ? hit_way : r_way;
    assign snp_act  = snp_valid && s_hit;
    assign collide  = snp_act && (s_idx == r_idx) && (s_way == fsm_way);
    // The incoming fill replaces the victim's old tag, so a snoop on that dying line is dropped.
    assign snp_do   = snp_act && !(install && s_idx == r_idx && s_way == r_way);

    always_comb begin
        state_n    = state;
        wr_byte    = 1'b0;
        inv_vic    = 1'b0;
        install    = 1'b0;
        upd_cst    = 1'b0;
        lru_touch  = 1'b0;
        req_ready  = (state == IDLE) && reset;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        resp_rdata = 8'h00;
        bus_req    = 1'b0;
        bus_cmd    = CMD_NONE;
        bus_addr   = '0;
        bus_wdata  = '0;
        case (state)
            IDLE: if (req_valid && reset) state_n = LOOKUP;
            LOOKUP: begin
                if (!hit) state_n = VICTIM;
                else if (!r_write) state_n = RESPOND;
                else if (!collide) begin
                    wr_byte = 1'b1;
                    state_n = (hit_cst == CS_E || hit_cst == CS_M) ? RESPOND : UPDATE;
                end
            end
            VICTIM: state_n = (valid_mem[r_idx][vic_way] && (vic_cst == CS_M || vic_cst == CS_SM))
                              ? FLUSH : FILL_REQ;
            FLUSH: begin
                bus_req   = 1'b1;
                bus_cmd   = CMD_FLUSH;
                bus_addr  = {tag_mem[r_idx][r_way], r_idx, {OFF_W{1'b0}}};
                bus_wdata = cur_line;
                if (bus_gnt && !collide) begin
                    inv_vic = 1'b1;
                    state_n = FILL_REQ;
                end
            end
            FILL_REQ: begin
                bus_req  = 1'b1;
                bus_cmd  = CMD_BUSRD;
                bus_addr = {r_tag, r_idx, {OFF_W{1'b0}}};
                if (bus_gnt) state_n = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (bus_rvalid) begin
                    install = 1'b1;
                    state_n = r_write ? UPDATE : RESPOND;
                end
            end
            UPDATE: begin
                bus_req   = 1'b1;
                bus_cmd   = CMD_BUSUPD;
                bus_addr  = r_addr;
                bus_wdata = LINE_W'(r_wdata);
                if (bus_gnt && !collide) begin
                    upd_cst = 1'b1;
                    state_n = RESPOND;
                end
            end
            RESPOND: begin
                resp_valid = 1'b1;
                resp_hit   = r_hit;
                resp_rdata = r_write ? 8'h00 : cur_line[{r_off, 3'b000} +: 8];
                lru_touch  = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= 8'h00;
            r_hit   <= 1'b0;
            r_way   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req_valid) begin
                r_addr  <= req_addr;
                r_write <= req_write;
                r_wdata <= req_wdata;
            end
            if (state == LOOKUP) begin
                r_hit <= hit;
                r_way <= hit_way;
            end
            if (state == VICTIM) r_way <= vic_way;
        end
    end

    // Coherence state, valid and age; snoop assignments come last so they win.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_mem[s][w] <= 1'b0;
                    cst_mem[s][w]   <= CS_E;
                    age_mem[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            if (wr_byte && (hit_cst == CS_E || hit_cst == CS_M)) cst_mem[r_idx][hit_way] <= CS_M;
            if (inv_vic) valid_mem[r_idx][r_way] <= 1'b0;
            if (install) begin
                valid_mem[r_idx][r_way] <= 1'b1;
                cst_mem[r_idx][r_way]   <= r_write ? CS_M : (bus_shared ? CS_SC : CS_E);
            end
            if (upd_cst) cst_mem[r_idx][r_way] <= bus_shared ? CS_SM : CS_M;
            if (lru_touch) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (w == int'(r_way)) age_mem[r_idx][w] <= '0;
                    else if (age_mem[r_idx][w] < age_mem[r_idx][r_way])
                        age_mem[r_idx][w] <= age_mem[r_idx][w] + 1'b1;
                end
            end
            if (snp_do) begin
                if (snp_cmd == CMD_BUSRD) begin
                    if (cst_mem[s_idx][s_way] == CS_E) cst_mem[s_idx][s_way] <= CS_SC;
                    if (cst_mem[s_idx][s_way] == CS_M) cst_mem[s_idx][s_way] <= CS_SM;
                end else if (snp_cmd == CMD_BUSUPD && cst_mem[s_idx][s_way] == CS_SM) begin
                    cst_mem[s_idx][s_way] <= CS_SC;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_byte) data_mem[r_idx][hit_way] <= put_byte(data_mem[r_idx][hit_way], r_off, r_wdata);
        if (install) begin
            data_mem[r_idx][r_way] <= r_write ? put_byte(bus_rdata, r_off, r_wdata) : bus_rdata;
            tag_mem[r_idx][r_way]  <= r_tag;
        end
        if (snp_do && snp_cmd == CMD_BUSUPD)
            data_mem[s_idx][s_way] <= put_byte(data_mem[s_idx][s_way], s_off, snp_data);
    end
endmodule

// File: tb/tb_dragon_cache_ctrl.sv
// tb/tb_dragon_cache_ctrl.sv - randomized bench with a recency-list cache model
module tb_dragon_cache_ctrl;
    localparam int SETS = 256;
    localparam int WAYS = 4;
    localparam int ST_E = 0, ST_SC = 1, ST_SM = 2, ST_M = 3;

    logic        clock = 1'b0;
    logic        reset, req_valid, req_ready, req_write, resp_valid, resp_hit;
    logic [15:0] req_addr, bus_addr, snp_addr;
    logic [7:0]  req_wdata, resp_rdata, snp_data;
    logic        bus_req, bus_gnt, bus_shared, bus_rvalid, snp_valid, snp_shared;
    logic [1:0]  bus_cmd, snp_cmd;
    logic [31:0] bus_wdata, bus_rdata;

    always #5 clock = ~clock;

    dragon_cache_ctrl #(.ADDR_W(16), .SETS(SETS), .WAYS(WAYS), .LINE_BYTES(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_shared(bus_shared), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .snp_valid(snp_valid), .snp_cmd(snp_cmd),
        .snp_addr(snp_addr), .snp_data(snp_data), .snp_shared(snp_shared)
    );

    int checks = 0;
    int errors = 0;

    bit          m_valid [SETS][WAYS];
    logic [5:0]  m_tag   [SETS][WAYS];
    int          m_st    [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS];
    int          m_ord   [SETS][$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ord[s] = {};
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_ord[s].push_back(w);
            end
        end
    endtask

    task automatic touch(input int s, input int w);
        for (int p = 0; p < m_ord[s].size(); p++)
            if (m_ord[s][p] == w) begin
                m_ord[s].delete(p);
                break;
            end
        m_ord[s].push_front(w);
    endtask

    task automatic lookup(input logic [15:0] a, output bit h, output int w);
        h = 1'b0;
        w = 0;
        for (int i = 0; i < WAYS; i++)
            if (m_valid[a[9:2]][i] && m_tag[a[9:2]][i] == a[15:10]) begin
                h = 1'b1;
                w = i;
            end
    endtask

    task automatic do_req(input bit wr, input logic [15:0] a, input logic [7:0] wd,
                          input bit fsh, input bit ush, input logic [31:0] fdata,
                          output bit obs_hit);
        int idx, off, w, ne, k, gdly, fcnt, rcyc;
        bit h, done;
        logic [1:0]  e_cmd  [3];
        logic [15:0] e_addr [3];
        logic [31:0] e_data [3];
        logic [31:0] line;
        idx = int'(a[9:2]);
        off = int'(a[1:0]);
        ne = 0;
        lookup(a, h, w);
        if (h) begin
            line = m_data[idx][w];
            if (wr && (m_st[idx][w] == ST_SC || m_st[idx][w] == ST_SM)) begin
                e_cmd[ne] = 2'd2; e_addr[ne] = a; e_data[ne] = {24'h0, wd}; ne++;
            end
        end else begin
            w = -1;
            for (int i = 0; i < WAYS; i++) if (w < 0 && !m_valid[idx][i]) w = i;
            if (w < 0) w = m_ord[idx][$];
            if (m_valid[idx][w] && (m_st[idx][w] == ST_SM || m_st[idx][w] == ST_M)) begin
                e_cmd[ne] = 2'd3; e_addr[ne] = {m_tag[idx][w], a[9:2], 2'b00};
                e_data[ne] = m_data[idx][w]; ne++;
            end
            e_cmd[ne] = 2'd1; e_addr[ne] = {a[15:2], 2'b00}; e_data[ne] = '0; ne++;
            if (wr) begin
                e_cmd[ne] = 2'd2; e_addr[ne] = a; e_data[ne] = {24'h0, wd}; ne++;
            end
            line = fdata;
        end
        if (wr) line[off*8 +: 8] = wd;

        @(negedge clock);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        @(negedge clock);
        req_valid = 1'b0;
        k = 0; gdly = $urandom_range(0, 2); fcnt = -1; done = 1'b0; rcyc = 0; obs_hit = 1'b0;
        for (int c = 1; c <= 80 && !done; c++) begin
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_shared = 1'b0;
            if (resp_valid) begin
                chk("resp_hit", resp_hit, h);
                chk("resp_rdata", resp_rdata, wr ? 8'h00 : line[off*8 +: 8]);
                obs_hit = resp_hit;
                rcyc = c;
                done = 1'b1;
            end else if (bus_req) begin
                chk("bus_req_expected", k < ne, 1);
                if (k < ne) begin
                    chk("bus_cmd", bus_cmd, e_cmd[k]);
                    chk("bus_addr", bus_addr, e_addr[k]);
                    if (e_cmd[k] != 2'd1) chk("bus_wdata", bus_wdata, e_data[k]);
                    if (gdly == 0) begin
                        bus_gnt = 1'b1;
                        if (e_cmd[k] == 2'd2) bus_shared = ush;
                        if (e_cmd[k] == 2'd1) fcnt = $urandom_range(1, 3);
                        k++;
                        gdly = $urandom_range(0, 2);
                    end else gdly--;
                end
            end else if (fcnt > 0) begin
                fcnt--;
                if (fcnt == 0) begin
                    bus_rvalid = 1'b1; bus_rdata = fdata; bus_shared = fsh;
                end
            end
            if (!done) @(negedge clock);
        end
        chk("resp_seen", done, 1);
        chk("bus_txn_count", k, ne);
        if (ne == 0) chk("hit_latency", rcyc, 2);
        @(negedge clock);
        chk("resp_single_pulse", resp_valid, 0);

        m_data[idx][w] = line;
        if (!h) begin
            m_valid[idx][w] = 1'b1;
            m_tag[idx][w] = a[15:10];
            m_st[idx][w] = wr ? (ush ? ST_SM : ST_M) : (fsh ? ST_SC : ST_E);
        end else if (wr) begin
            if (m_st[idx][w] == ST_E || m_st[idx][w] == ST_M) m_st[idx][w] = ST_M;
            else m_st[idx][w] = ush ? ST_SM : ST_M;
        end
        touch(idx, w);
    endtask

    task automatic snoop(input logic [1:0] cmd, input logic [15:0] a, input logic [7:0] d);
        bit h;
        int w, idx;
        idx = int'(a[9:2]);
        lookup(a, h, w);
        @(negedge clock);
        snp_valid = 1'b1; snp_cmd = cmd; snp_addr = a; snp_data = d;
        #1;
        chk("snp_shared", snp_shared, h);
        @(negedge clock);
        snp_valid = 1'b0;
        if (h) begin
            if (cmd == 2'd1) begin
                if (m_st[idx][w] == ST_E) m_st[idx][w] = ST_SC;
                else if (m_st[idx][w] == ST_M) m_st[idx][w] = ST_SM;
            end else if (cmd == 2'd2) begin
                m_data[idx][w][int'(a[1:0])*8 +: 8] = d;
                if (m_st[idx][w] == ST_SM) m_st[idx][w] = ST_SC;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit h, found;
        logic [15:0] a;
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        bus_gnt = 1'b0; bus_shared = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        snp_valid = 1'b0; snp_cmd = '0; snp_addr = '0; snp_data = '0;
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_cmd", bus_cmd, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_snp_shared", snp_shared, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", req_ready, 1);

        do_req(0, 16'h1234, 8'h00, 0, 0, 32'hA1B2C3D4, h);
        chk("first_read_miss", h, 0);
        do_req(0, 16'h1234, 8'h00, 0, 0, 32'h0, h);
        chk("reread_hit", h, 1);
        do_req(1, 16'h1234, 8'h55, 0, 0, 32'h0, h);
        for (int t = 1; t <= 4; t++)
            do_req(0, 16'h1234 + 16'(t * 16'h0400), 8'h00, 0, 0, $urandom, h);

        do_req(0, 16'h2238, 8'h00, 1, 0, 32'h11223344, h);
        do_req(1, 16'h2238, 8'hAB, 0, 1, 32'h0, h);
        do_req(1, 16'h2238, 8'hCD, 0, 0, 32'h0, h);
        do_req(1, 16'h2238, 8'hEF, 0, 0, 32'h0, h);
        snoop(2'd1, 16'h2238, 8'h00);
        snoop(2'd2, 16'h2239, 8'h77);
        do_req(0, 16'h2239, 8'h00, 0, 0, 32'h0, h);
        chk("snoop_upd_hit", h, 1);
        do_req(1, 16'h2238, 8'h01, 0, 1, 32'h0, h);

        for (int t = 0; t < 4; t++) do_req(0, {6'(t), 8'h10, 2'b00}, 8'h00, 0, 0, $urandom, h);
        do_req(0, {6'd0, 8'h10, 2'b00}, 8'h00, 0, 0, 32'h0, h);
        do_req(0, {6'd4, 8'h10, 2'b00}, 8'h00, 0, 0, $urandom, h);
        do_req(0, {6'd1, 8'h10, 2'b00}, 8'h00, 0, 0, $urandom, h);
        chk("lru_evicted_way1", h, 0);
        do_req(0, {6'd0, 8'h10, 2'b00}, 8'h00, 0, 0, 32'h0, h);
        chk("lru_kept_way0", h, 1);

        for (int t = 0; t < 300; t++) begin
            a = {6'($urandom_range(0, 5)), 8'h40 + 8'($urandom_range(0, 1)), 2'($urandom)};
            if ($urandom_range(0, 9) < 7)
                do_req(1'($urandom), a, 8'($urandom), 1'($urandom), 1'($urandom), $urandom, h);
            else
                snoop(2'($urandom_range(1, 3)), a, 8'($urandom));
        end

        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h5678;
        @(negedge clock);
        req_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (bus_req && bus_cmd == 2'd1) found = 1'b1;
            else @(negedge clock);
        end
        chk("fw_busrd_seen", found, 1);
        bus_gnt = 1'b1;
        @(negedge clock);
        bus_gnt = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("fw_rst_bus_req", bus_req, 0);
        chk("fw_rst_req_ready", req_ready, 0);
        chk("fw_rst_resp_valid", resp_valid, 0);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        chk("fw_post_ready", req_ready, 1);
        do_req(0, 16'h5678, 8'h00, 0, 0, 32'hCAFEF00D, h);
        chk("fw_reread_miss", h, 0);
        do_req(0, 16'h1234, 8'h00, 0, 0, 32'h0BADBEEF, h);
        chk("fw_old_line_gone", h, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dragon_cache_ctrl.md
Name: dragon_cache_ctrl

Overview:
- Parametrised write-back, set-associative private cache controller implementing the Dragon update protocol (E, Sc, Sm, M).
- Sits between one processor request port and the shared snooping bus.
- Generalises the fixed 256x4 cache. Adds configurable sets, ways and line size, a valid/ready handshake, explicit bus arbitration, write-back of dirty victims, true age-based LRU and a same-cycle shared response to snoops.

Parameters:
- ADDR_W, 16, processor byte-address width.
- SETS, 256, number of sets; power of two.
- WAYS, 4, associativity; power of two, 2..16.
- LINE_BYTES, 4, bytes per line; power of two.
- Derived: OFF_W=log2(LINE_BYTES), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W; address = {tag, index, offset}.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  processor request valid.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  8  write byte.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  8  read byte; 0 for writes.
- resp_hit  out  1  request hit, qualified by resp_valid.
- bus_req  out  1  bus request to arbiter.
- bus_gnt  in  1  bus grant.
- bus_cmd  out  2  0=NONE 1=BUSRD 2=BUSUPD 3=FLUSH.
- bus_addr  out  ADDR_W  line address (offset 0), or byte address for BUSUPD.
- bus_wdata  out  8*LINE_BYTES  flush line; byte 0 carries the BUSUPD byte.
- bus_shared  in  1  another cache holds the line; sampled with bus_rvalid and on the BUSUPD grant cycle.
- bus_rvalid  in  1  fill data valid.
- bus_rdata  in  8*LINE_BYTES  fill line.
- snp_valid  in  1  a foreign bus transaction is visible.
- snp_cmd  in  2  encoded as bus_cmd.
- snp_addr  in  ADDR_W  snooped address.
- snp_data  in  8  BUSUPD byte.
- snp_shared  out  1  combinational: a valid tag match exists for snp_addr.

Behaviour:
- Reset (reset=0 at an edge, in any state, including mid-transaction):
  - FSM goes to IDLE; all valid bits clear.
  - LRU age of way w in every set is w.
  - req_ready=0 during reset, 1 in the first IDLE cycle after release.
  - resp_valid=0, resp_rdata=0, resp_hit=0, bus_req=0, bus_cmd=NONE, bus_addr=0, bus_wdata=0.
  - An abandoned bus transaction is dropped; no retry.
- Handshake:
  - A request is accepted when req_valid&&req_ready; the controller latches addr, write and wdata.
  - req_ready=1 only in IDLE.
  - Exactly one resp_valid pulse per accepted request.
- FSM states: IDLE, LOOKUP, VICTIM, FLUSH, FILL_REQ, FILL_WAIT, UPDATE, RESPOND.
- IDLE -> LOOKUP on accept.
- LOOKUP: tag compare across all ways.
  - Read hit -> RESPOND.
  - Write hit in E or M -> write byte, state becomes M -> RESPOND.
  - Write hit in Sc or Sm -> write byte -> UPDATE.
  - Miss -> VICTIM.
- Hit latency: accept at edge N, resp_valid high in cycle N+2.
- VICTIM: pick the lowest-numbered invalid way, else the way with age WAYS-1.
  - Victim in M or Sm -> FLUSH; otherwise -> FILL_REQ.
- FLUSH: bus_req=1, bus_cmd=FLUSH, bus_addr and bus_wdata carry the victim line. On the bus_gnt cycle invalidate the victim -> FILL_REQ.
- FILL_REQ: bus_req=1, bus_cmd=BUSRD until bus_gnt -> FILL_WAIT.
- FILL_WAIT: bus_cmd=NONE; wait for bus_rvalid, then install the line, tag and valid.
  - Read miss: state Sc if bus_shared else E -> RESPOND.
  - Write miss: merge the byte -> UPDATE.
- UPDATE: bus_req=1, bus_cmd=BUSUPD with the byte address until bus_gnt.
  - bus_shared on the grant cycle -> Sm; otherwise M.
  - Then -> RESPOND.
- RESPOND: resp_valid=1. resp_hit reflects the LOOKUP result. resp_rdata is the selected byte for reads, 0 for writes. LRU is updated. -> IDLE.
- bus_req and bus_cmd hold stable until bus_gnt. bus_req drops the cycle after the grant.
- LRU update: the accessed way's age becomes 0. Every way with a smaller age than the accessed way's old age increments. Ages stay a permutation of 0..WAYS-1.
- Snoop, on a valid tag match only:
  - BUSRD: E->Sc, M->Sm; Sc and Sm unchanged.
  - BUSUPD: write snp_data into the byte; Sm->Sc, others unchanged.
  - FLUSH: no state change.
  - Snoops never change LRU.
- Snoop updates apply at the edge ending the snp_valid cycle.
- Snoop/FSM collision: a snoop applied in the same cycle as an FSM array write to the same set and way takes precedence. The FSM holds its state one extra cycle and re-evaluates.
- Snoop while in FILL_WAIT to the pending line address: ignored, because the line is not yet valid.

Test Plan:
- Reset release, then read 0x1234 (no bus_shared) -> miss, BUSRD 0x1234, fill 0xA1B2C3D4 -> resp_rdata is the selected byte, resp_hit=0, state E; re-read -> hit at N+2, resp_hit=1.
- Write 0x55 to an E line -> no bus activity, state M. Fill all 4 ways of the set, then miss -> FLUSH of the M line carrying 0x55, then BUSRD.
- Write hit to an Sc line with bus_shared=1 on the grant -> BUSUPD issued, state Sm. Repeat with bus_shared=0 -> state M.
- Snoop BUSRD to an M line -> snp_shared=1 the same cycle, state Sm. Snoop BUSUPD data 0x77 -> byte becomes 0x77, state Sc.
- LRU: accesses to ways 0,1,2,3,0 then a miss -> victim is way 1.
- Reset asserted in FILL_WAIT -> next cycle bus_req=0, req_ready=0, all lines invalid; after release a read of the same address misses.
